div64_host: RTL and testbench

Host-side sequencer for the 64-bit divider accelerator's chunked control protocol. It accepts a 64-bit dividend/divisor pair on a valid/ready port and drives `mb_cnt`/`from_mb` to load the operands as four 32-bit chunks. It then starts the division and reads back remainder and quotient through `out_chunk`/`cnt_div`, presenting a 64-bit result pair on a second valid/ready port. This replaces the software chunk loop so fabric logic can use the divider directly.

---
 rtl/div64_pkg.sv | 32 +++
 rtl/div64_timeout.sv | 38 +++
 rtl/div64_host.sv | 149 ++++++++++++++
 tb/tb_div64_host.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div64_pkg.sv
// rtl/div64_pkg.sv - shared codes and state enum for the div64 host sequencer
// Divider state codes, host phase codes, chunk counts and the host FSM states.
package div64_pkg;

  localparam logic [2:0] DIV_IDLE = 3'd0;
  localparam logic [2:0] DIV_IN_A = 3'd1;
  localparam logic [2:0] DIV_IN_B = 3'd2;
  localparam logic [2:0] DIV_WB   = 3'd5;

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_LOAD_A = 3'd1;
  localparam logic [2:0] PH_LOAD_B = 3'd2;
  localparam logic [2:0] PH_GO     = 3'd3;
  localparam logic [2:0] PH_READ   = 3'd4;

  localparam logic [2:0] CNT_ARM  = 3'd7;
  localparam logic [2:0] CNT_A_LO = 3'd1;
  localparam logic [2:0] CNT_A_HI = 3'd2;
  localparam logic [2:0] CNT_B_LO = 3'd0;
  localparam logic [2:0] CNT_B_HI = 3'd1;
  localparam logic [2:0] CNT_GO   = 3'd0;

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_A_LO, S_A_HI, S_B_LO, S_B_HI, S_GO,
    S_RD3, S_RD2, S_RD1, S_RD0, S_RELEASE, S_ABORT, S_RESULT
  } host_state_e;

  function automatic logic [6:0] mb_word(input logic [2:0] ph, input logic [2:0] cnt);
    return {ph, 1'b1, cnt};
  endfunction

endpackage

// File: rtl/div64_timeout.sv
// rtl/div64_timeout.sv - per-state wait counter for the div64 host
// Counts cycles while enabled; expired_o flags the TIMEOUT_CYCLES-th cycle in a state.
module div64_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div64_host.sv
// rtl/div64_host.sv - chunked-protocol sequencer driving the 64-bit divider
// Loads operands as four 32-bit chunks, starts the divide, reads back r/q, presents the result.
module div64_host
  import div64_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_q,
  output logic [63:0] res_r,
  output logic        res_dbz,
  output logic        res_err,
  output logic        busy,
  output logic [6:0]  mb_cnt,
  output logic [31:0] from_mb,
  input  logic [31:0] out_chunk,
  input  logic [6:0]  cnt_div
);

  host_state_e state_q, state_d, nxt;
  logic        adv, wait_st, tmo_exp;
  logic [6:0]  mb_cnt_q, mb_cnt_d;
  logic [31:0] from_mb_q, from_mb_d;
  logic [63:0] a_q, b_q, quo_q, rem_q;
  logic        dbz_q, err_q;
  logic [2:0]  div_state;
  logic [3:0]  div_cnt;

  assign div_state = cnt_div[6:4];
  assign div_cnt   = cnt_div[3:0];

  assign op_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_RESULT);
  assign res_q     = quo_q;
  assign res_r     = rem_q;
  assign res_dbz   = dbz_q;
  assign res_err   = err_q;
  assign mb_cnt    = mb_cnt_q;
  assign from_mb   = from_mb_q;

  // Each wait state checks a cnt_div value the previous step cannot leave behind.
  always_comb begin
    adv     = 1'b0;
    nxt     = state_q;
    wait_st = 1'b1;
    case (state_q)
      S_ARM:     begin nxt = S_A_LO;    adv = (div_state == DIV_IN_A); end
      S_A_LO:    begin nxt = S_A_HI;    adv = (div_cnt == 4'd1); end
      S_A_HI:    begin nxt = S_B_LO;    adv = (div_cnt == 4'd0); end
      S_B_LO:    begin nxt = S_B_HI;    adv = (div_state == DIV_IN_B) && (div_cnt == 4'd1); end
      S_B_HI:    begin nxt = S_GO;      adv = (div_cnt == 4'd0); end
      S_GO:      begin nxt = S_RD3;     adv = (div_state == DIV_WB); end
      S_RD3:     begin nxt = S_RD2;     adv = (div_state == DIV_WB) && (div_cnt == 4'd3); end
      S_RD2:     begin nxt = S_RD1;     adv = (div_state == DIV_WB) && (div_cnt == 4'd2); end
      S_RD1:     begin nxt = S_RD0;     adv = (div_state == DIV_WB) && (div_cnt == 4'd1); end
      S_RD0:     begin nxt = S_RELEASE; adv = (div_state == DIV_WB) && (div_cnt == 4'd0); end
      S_RELEASE: begin nxt = S_RESULT;  adv = (div_state == DIV_IDLE); end
      default:   wait_st = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (op_valid) state_d = (op_b == 64'd0) ? S_RESULT : S_ARM;
      S_ABORT:  state_d = S_RESULT;
      S_RESULT: if (res_ready) state_d = S_IDLE;
      default: begin
        if (adv) state_d = nxt;
        else if (tmo_exp) state_d = S_ABORT;
      end
    endcase
  end

  // mb_cnt/from_mb are registered from the next state so they change on the entry edge.
  always_comb begin
    mb_cnt_d  = '0;
    from_mb_d = '0;
    case (state_d)
      S_ARM:  mb_cnt_d = mb_word(PH_LOAD_A, CNT_ARM);
      S_A_LO: begin mb_cnt_d = mb_word(PH_LOAD_A, CNT_A_LO); from_mb_d = a_q[31:0];  end
      S_A_HI: begin mb_cnt_d = mb_word(PH_LOAD_A, CNT_A_HI); from_mb_d = a_q[63:32]; end
      S_B_LO: begin mb_cnt_d = mb_word(PH_LOAD_B, CNT_B_LO); from_mb_d = b_q[31:0];  end
      S_B_HI: begin mb_cnt_d = mb_word(PH_LOAD_B, CNT_B_HI); from_mb_d = b_q[63:32]; end
      S_GO:   mb_cnt_d = mb_word(PH_GO, CNT_GO);
      S_RD3:  mb_cnt_d = mb_word(PH_READ, 3'd3);
      S_RD2:  mb_cnt_d = mb_word(PH_READ, 3'd2);
      S_RD1:  mb_cnt_d = mb_word(PH_READ, 3'd1);
      S_RD0:  mb_cnt_d = mb_word(PH_READ, 3'd0);
      default: ;
    endcase
  end

  div64_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .rst_n_i  (reset),
    .clr_i    (state_d != state_q),
    .en_i     (wait_st),
    .expired_o(tmo_exp)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mb_cnt_q  <= '0;
      from_mb_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mb_cnt_q  <= mb_cnt_d;
      from_mb_q <= from_mb_d;
      if (state_q == S_IDLE && op_valid) begin
        a_q   <= op_a;
        b_q   <= op_b;
        err_q <= 1'b0;
        dbz_q <= (op_b == 64'd0);
        quo_q <= (op_b == 64'd0) ? '1 : '0;
        rem_q <= (op_b == 64'd0) ? op_a : '0;
      end else if (adv) begin
        case (state_q)
          S_RD3: rem_q[31:0]  <= out_chunk;
          S_RD2: rem_q[63:32] <= out_chunk;
          S_RD1: quo_q[31:0]  <= out_chunk;
          S_RD0: quo_q[63:32] <= out_chunk;
          default: ;
        endcase
      end else if (state_d == S_ABORT) begin
        quo_q <= '0;
        rem_q <= '0;
        dbz_q <= 1'b0;
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div64_host.sv
// tb/tb_div64_host.sv - self-checking bench for div64_host with a behavioural divider
// The divider model reacts to mb_cnt/from_mb and computes q/r from the chunks it received.
module tb_div64_host;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [63:0] op_a = '0, op_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_q, res_r;
  logic        res_dbz, res_err, busy;
  logic [6:0]  mb_cnt;
  logic [31:0] from_mb;
  logic [31:0] out_chunk;
  logic [6:0]  cnt_div;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div64_host #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_r(res_r),
    .res_dbz(res_dbz), .res_err(res_err), .busy(busy),
    .mb_cnt(mb_cnt), .from_mb(from_mb), .out_chunk(out_chunk), .cnt_div(cnt_div)
  );

  // Behavioural divider
  logic [2:0]  dst = 3'd0;
  logic [3:0]  dcnt = 4'd0;
  logic [31:0] ochunk = '0;
  logic [63:0] ma = '0, mb = '0, mq = '0, mr = '0;
  int          lat_left = 0;
  int          lat_sel = 4;
  bit          hang = 1'b0;
  logic [2:0]  ph, c;

  assign cnt_div   = {dst, dcnt};
  assign out_chunk = ochunk;

  always @(posedge clk) begin
    ph = mb_cnt[6:4];
    c  = mb_cnt[2:0];
    if (ph == 3'd0) begin
      dst <= 3'd0; dcnt <= 4'd0;
    end else begin
      case (dst)
        3'd0: if (ph == 3'd1 && mb_cnt[3] && c == 3'd7) begin dst <= 3'd1; dcnt <= 4'd2; end
        3'd1: begin
          if (ph == 3'd1 && c == 3'd1) begin ma[31:0] <= from_mb; dcnt <= 4'd1; end
          else if (ph == 3'd1 && c == 3'd2) begin ma[63:32] <= from_mb; dcnt <= 4'd0; end
          else if (ph == 3'd2 && c == 3'd0) begin mb[31:0] <= from_mb; dst <= 3'd2; dcnt <= 4'd1; end
        end
        3'd2: begin
          if (ph == 3'd2 && c == 3'd1) begin mb[63:32] <= from_mb; dcnt <= 4'd0; end
          else if (ph == 3'd3) begin dst <= 3'd3; lat_left <= lat_sel; dcnt <= 4'(lat_sel); end
        end
        3'd3: if (!hang) begin
          if (lat_left <= 1) begin dst <= 3'd5; dcnt <= 4'd4; mq <= ma / mb; mr <= ma % mb; end
          else lat_left <= lat_left - 1;
        end
        3'd5: if (ph == 3'd4) begin
          dcnt <= {1'b0, c};
          case (c)
            3'd3: ochunk <= mr[31:0];
            3'd2: ochunk <= mr[63:32];
            3'd1: ochunk <= mq[31:0];
            default: ochunk <= mq[63:32];
          endcase
        end
        default: ;
      endcase
    end
  end

  logic [6:0] exp_seq [0:10] = '{7'h1F, 7'h19, 7'h1A, 7'h28, 7'h29, 7'h38,
                                 7'h4B, 7'h4A, 7'h49, 7'h48, 7'h00};
  logic [6:0] seq_v[$];
  int         seq_n[$];
  int         cyc;

  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    op_a = a; op_b = b; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic wait_result();
    seq_v.delete(); seq_n.delete(); cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (seq_v.size() == 0 || seq_v[$] !== mb_cnt) begin
        seq_v.push_back(mb_cnt); seq_n.push_back(1);
      end else begin
        seq_n[seq_n.size()-1] = seq_n[seq_n.size()-1] + 1;
      end
      if (res_valid) break;
      if (cyc >= 400) begin
        checks++; errors++;
        $display("FAIL result_wait: res_valid=%0b after %0d cycles, required 1", res_valid, cyc);
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({mb_cnt, from_mb} !== 39'd0) begin errors++; $display("FAIL reset_mb: mb_cnt=%h from_mb=%h required 0", mb_cnt, from_mb); end
    checks++; if ({op_ready, busy, res_valid} !== 3'b100) begin errors++; $display("FAIL reset_hs: rdy/busy/vld=%b required 100", {op_ready, busy, res_valid}); end
    checks++; if ({res_q, res_r, res_dbz, res_err} !== 130'd0) begin errors++; $display("FAIL reset_res: q=%h r=%h dbz=%b err=%b required 0", res_q, res_r, res_dbz, res_err); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: %b required 1", op_ready); end
  endtask

  task automatic test_basic();
    lat_sel = 5;
    issue(64'd100, 64'd7);
    wait_result();
    checks++; if (res_q !== 64'd14 || res_r !== 64'd2) begin errors++; $display("FAIL basic_qr: q=%0d r=%0d required 14 2", res_q, res_r); end
    checks++; if ({res_dbz, res_err} !== 2'b00) begin errors++; $display("FAIL basic_flags: dbz/err=%b required 00", {res_dbz, res_err}); end
    checks++;
    if (seq_v.size() != 11) begin
      errors++; $display("FAIL basic_seq_len: %0d steps required 11", seq_v.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        checks++;
        if (seq_v[i] !== exp_seq[i]) begin errors++; $display("FAIL basic_seq[%0d]: mb_cnt=%h required %h", i, seq_v[i], exp_seq[i]); end
        if (i < 10) begin
          checks++;
          if (seq_n[i] != ((i == 5) ? 2 + lat_sel : 2)) begin
            errors++; $display("FAIL basic_step_len[%0d]: %0d cycles required %0d", i, seq_n[i], (i == 5) ? 2 + lat_sel : 2);
          end
        end
      end
    end
    ack();
    checks++; if (op_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL basic_done: rdy=%b vld=%b required 1 0", op_ready, res_valid); end
  endtask

  task automatic run_check(input string nm, input logic [63:0] a, input logic [63:0] b);
    lat_sel = $urandom_range(1, 8);
    issue(a, b);
    wait_result();
    checks++;
    if (res_q !== a / b || res_r !== a % b || res_dbz !== 1'b0 || res_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: a=%h b=%h q=%h r=%h d/e=%b%b required q=%h r=%h 00", nm, a, b, res_q, res_r, res_dbz, res_err, a / b, a % b);
    end
    checks++;
    if (seq_v.size() != 11 || seq_n[5] != 2 + lat_sel) begin
      errors++; $display("FAIL %s_go_len: steps=%0d go=%0d required 11 %0d", nm, seq_v.size(), seq_n[5], 2 + lat_sel);
    end
    ack();
  endtask

  task automatic test_boundary();
    run_check("bound_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    run_check("bound_32", 64'h1_0000_0000, 64'h1_0000_0001);
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    for (int i = 0; i < 12; i++) begin
      a = {$urandom(), $urandom()};
      case (i % 3)
        0: b = 64'($urandom_range(1, 1000));
        1: b = {32'd0, $urandom() | 32'd1};
        default: b = {$urandom() | 32'h1, $urandom()};
      endcase
      run_check("random", a, b);
    end
  endtask

  task automatic test_dbz();
    logic [63:0] a;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 64'h1234 : {$urandom(), $urandom()};
      issue(a, 64'd0);
      wait_result();
      checks++; if (cyc != 1) begin errors++; $display("FAIL dbz_latency: %0d cycles required 1", cyc); end
      checks++;
      if (res_q !== '1 || res_r !== a || res_dbz !== 1'b1 || res_err !== 1'b0) begin
        errors++; $display("FAIL dbz_result: q=%h r=%h d/e=%b%b required all-ones %h 10", res_q, res_r, res_dbz, res_err, a);
      end
      checks++; if (seq_v.size() != 1 || mb_cnt !== 7'd0) begin errors++; $display("FAIL dbz_mb: steps=%0d mb_cnt=%h required 1 0", seq_v.size(), mb_cnt); end
      ack();
    end
  endtask

  task automatic test_timeout();
    hang = 1'b1;
    issue(64'd55, 64'd5);
    wait_result();
    checks++;
    if (seq_v.size() != 7 || seq_v[5] !== 7'h38 || seq_n[5] != 16 || seq_n[6] != 2) begin
      errors++; $display("FAIL tmo_seq: steps=%0d go=%0d abort+res=%0d required 7 16 2", seq_v.size(), seq_n[5], seq_n[6]);
    end
    checks++;
    if (res_err !== 1'b1 || res_dbz !== 1'b0 || res_q !== 64'd0 || res_r !== 64'd0 || mb_cnt !== 7'd0) begin
      errors++; $display("FAIL tmo_result: err=%b dbz=%b q=%h r=%h mb=%h required 1 0 0 0 0", res_err, res_dbz, res_q, res_r, mb_cnt);
    end
    hang = 1'b0;
    ack();
    run_check("after_tmo", 64'd100, 64'd7);
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, sq, sr;
    a = 64'hDEAD_BEEF_1234_5678;
    b = 64'h1_0000_0003;
    lat_sel = 3;
    issue(a, b);
    wait_result();
    sq = res_q; sr = res_r;
    checks++; if (sq !== a / b || sr !== a % b) begin errors++; $display("FAIL bp_result: q=%h r=%h required %h %h", sq, sr, a / b, a % b); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || op_ready !== 1'b0 || res_q !== sq || res_r !== sr) begin
        errors++; $display("FAIL bp_hold[%0d]: vld=%b rdy=%b q=%h r=%h required 1 0 %h %h", i, res_valid, op_ready, res_q, res_r, sq, sr);
      end
    end
    ack();
    checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin errors++; $display("FAIL bp_release: vld=%b rdy=%b required 0 1", res_valid, op_ready); end
  endtask

  task automatic test_reset_mid();
    int n;
    lat_sel = 4;
    issue(64'h1122_3344_5566_7788, 64'd9);
    n = 0;
    while (mb_cnt !== 7'h29 && n < 50) begin @(negedge clk); n++; end
    checks++; if (mb_cnt !== 7'h29) begin errors++; $display("FAIL rst_mid_reach: mb_cnt=%h required 29", mb_cnt); end
    reset = 1'b0;
    #1;
    checks++;
    if (mb_cnt !== 7'd0 || from_mb !== 32'd0 || op_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 ||
        res_q !== 64'd0 || res_r !== 64'd0 || res_dbz !== 1'b0 || res_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: mb=%h fm=%h rdy=%b busy=%b vld=%b required reset values", mb_cnt, from_mb, op_ready, busy, res_valid);
    end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (cnt_div[6:4] !== 3'd0) begin errors++; $display("FAIL rst_mid_div_idle: div_state=%0d required 0", cnt_div[6:4]); end
    @(negedge clk);
    reset = 1'b1;
    run_check("after_rst", 64'd100, 64'd7);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_dbz();
    test_random();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
